stream_mux_nb_rr: RTL

// - N-input, NBITS-wide streaming mux: successor to the 1-bit 2:1 combinational mux.
// - Adds val/rdy handshakes on every input and the output, plus a one-entry output register.
// - Two runtime modes:
//   - explicit select (sel port)
//   - round-robin arbitration among valid inputs
// - Sits between multiple message producers and a single consumer; full throughput (1 msg/cycle).
//

---
 rtl/stream_mux_nb_rr_if.sv | 31 +++
 rtl/stream_mux_nb_rr.sv | 98 +++++++++
 2 files changed

// File: rtl/stream_mux_nb_rr_if.sv
// Handshake bundle between N producers, the streaming mux and one consumer.
// Handshake rule: a beat moves on a channel in a cycle where both its val
// and rdy are high at the rising clock edge; val never waits on rdy.
interface stream_mux_nb_rr_if #(
  parameter int NBITS   = 8,
  parameter int NINPUTS = 4
);
  localparam int SELW = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;

  logic                     mode;
  logic [SELW-1:0]          sel;
  logic [NINPUTS-1:0]       in_val;
  logic [NINPUTS-1:0]       in_rdy;
  logic [NINPUTS*NBITS-1:0] in_msg;
  logic                     out_val;
  logic                     out_rdy;
  logic [NBITS-1:0]         out_msg;
  logic [SELW-1:0]          out_src;

  // Producer/consumer side: drives inputs and out_rdy.
  modport master (
    output mode, sel, in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_src
  );

  // Mux side.
  modport slave (
    input  mode, sel, in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_src
  );
endinterface

// File: rtl/stream_mux_nb_rr.sv
// N-input streaming mux with explicit-select or round-robin arbitration and
// a one-entry output register that can drain and refill in the same cycle.
module stream_mux_nb_rr #(
  parameter int NBITS   = 8,
  parameter int NINPUTS = 4
) (
  input logic              clk,
  input logic              reset,
  stream_mux_nb_rr_if.slave bus
);
  localparam int SELW = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;

  logic             full_q, full_d;
  logic [NBITS-1:0] buf_msg_q, buf_msg_d;
  logic [SELW-1:0]  buf_src_q, buf_src_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             can_acc;
  logic [SELW-1:0]  grant;
  logic             gvld;
  logic [NBITS-1:0] grant_msg;
  logic             xfer_in;
  logic             xfer_out;

  // Register can take a new beat when empty or when it is draining this cycle.
  assign can_acc = !full_q || bus.out_rdy;

  // Grant selection: explicit sel, or first valid input after the last sender.
  always_comb begin
    grant = '0;
    gvld  = 1'b0;
    if (!bus.mode) begin
      if (int'(bus.sel) < NINPUTS) begin
        grant = bus.sel;
        gvld  = bus.in_val[bus.sel];
      end
    end else begin
      // Walk from farthest to nearest so the nearest valid input wins.
      for (int k = NINPUTS; k >= 1; k--) begin
        if (bus.in_val[(int'(last_q) + k) % NINPUTS]) begin
          grant = SELW'((int'(last_q) + k) % NINPUTS);
          gvld  = 1'b1;
        end
      end
    end
  end

  // Message of the granted input.
  always_comb begin
    grant_msg = bus.in_msg[int'(grant)*NBITS +: NBITS];
  end

  // One-hot ready to the granted input; held low while reset is asserted.
  always_comb begin
    bus.in_rdy = '0;
    if (reset && can_acc && gvld) begin
      bus.in_rdy[grant] = 1'b1;
    end
  end

  assign xfer_in  = gvld && can_acc;
  assign xfer_out = full_q && bus.out_rdy;

  // Next state of the output register and round-robin pointer.
  always_comb begin
    full_d    = full_q;
    buf_msg_d = buf_msg_q;
    buf_src_d = buf_src_q;
    last_d    = last_q;
    if (xfer_in) begin
      full_d    = 1'b1;
      buf_msg_d = grant_msg;
      buf_src_d = grant;
      last_d    = grant;
    end else if (xfer_out) begin
      full_d = 1'b0;
    end
  end

  // State registers; reset discards any buffered beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= 1'b0;
      buf_msg_q <= '0;
      buf_src_q <= '0;
      last_q    <= SELW'(NINPUTS - 1);
    end else begin
      full_q    <= full_d;
      buf_msg_q <= buf_msg_d;
      buf_src_q <= buf_src_d;
      last_q    <= last_d;
    end
  end

  assign bus.out_val = full_q;
  assign bus.out_msg = buf_msg_q;
  assign bus.out_src = buf_src_q;
endmodule
